// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: cycles each digit through an
// all-off guard window and an ON window, with frame-aligned value updates.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    upd_pending,
  output logic                    frame_done
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, GUARD, ON} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    wrap;
  logic                    xfer;
  logic [4*NUM_DIGITS-1:0] pending_q;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   zero_tail;
  logic                    all_zero;
  logic [3:0]              bcd_d;
  logic [NUM_DIGITS-1:0]   an_d;

  // Next-state logic; en=0 overrides every transition.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = GUARD;
        idx_d   = '0;
        cnt_d   = '0;
      end
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = GUARD;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      wrap    = 1'b0;
    end
  end

  // Shadow takes the pending value at a frame wrap, or immediately while idle.
  assign xfer     = upd_pending && (wrap || state_q == IDLE);
  assign shadow_d = xfer ? pending_q : shadow_q;

  // Outputs are computed from next-cycle values so registered outputs line up
  // with the state they describe; suppression uses the shadow being loaded.
  always_comb begin
    zero_tail = '0;
    all_zero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero     = all_zero && (shadow_d[4*k +: 4] == 4'd0);
      zero_tail[k] = all_zero;
    end
    bcd_d = 4'hF;
    an_d  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (state_d != IDLE && idx_d == IW'(k)) begin
        if (blank_lz && k != 0 && zero_tail[k])
          bcd_d = 4'hF;
        else
          bcd_d = shadow_d[4*k +: 4];
        if (state_d == ON)
          an_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      an          <= '1;
      bcd_out     <= 4'hF;
      frame_done  <= 1'b0;
      upd_pending <= 1'b0;
      pending_q   <= '0;
      shadow_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      an         <= an_d;
      bcd_out    <= bcd_d;
      frame_done <= wrap;
      shadow_q   <= shadow_d;
      if (load) begin
        pending_q   <= digits;
        upd_pending <= 1'b1;
      end else if (xfer) begin
        upd_pending <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4: number of multiplexed display digits (2..8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit is driven (ON period, >=1).
REQ-003 The block SHALL have parameter GUARD_CYC, default 16: all-anodes-off clock cycles before each digit (>=1).
REQ-004 The block SHALL have port clk  input  1: the single clock, rising-edge.
REQ-005 The block SHALL have port rst_n  input  1: reset, synchronous to clk, active-low.
REQ-006 The block SHALL have port en  input  1: scan enable.
REQ-007 The block SHALL have port digits  input  4*NUM_DIGITS: BCD values, digit k in bits [4k+3:4k], digit 0 least significant.
REQ-008 The block SHALL have port load  input  1: single-cycle request to capture digits.
REQ-009 The block SHALL have port blank_lz  input  1: leading-zero suppression enable.
REQ-010 The block SHALL have port bcd_out  output  4: code driven into the shared BCD-to-7-segment decoder.
REQ-011 The block SHALL have port an  output  NUM_DIGITS: active-low digit enables, an[k] drives digit k.
REQ-012 The block SHALL have port upd_pending  output  1: a captured value is waiting for a frame boundary.
REQ-013 The block SHALL have port frame_done  output  1: one-cycle pulse at the end of each full scan.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have states IDLE, GUARD and ON, plus a digit index idx (0..NUM_DIGITS-1) and a cycle counter.
REQ-016 In IDLE with en=1, the FSM SHALL enter GUARD with idx=0 on the next edge.
REQ-017 The FSM SHALL stay in GUARD exactly GUARD_CYC cycles with an all ones, then enter ON.
REQ-018 The FSM SHALL stay in ON exactly REFRESH_DIV cycles with an[idx]=0 and all other bits 1.
REQ-019 At the end of ON, idx SHALL advance by one and the FSM SHALL return to GUARD; after NUM_DIGITS-1, idx SHALL wrap to 0.
REQ-020 frame_done SHALL be 1 for the first GUARD cycle after a wrap from NUM_DIGITS-1 to 0, and 0 at all other times.
REQ-021 The frame period SHALL be NUM_DIGITS*(GUARD_CYC+REFRESH_DIV) cycles.
REQ-022 In both GUARD and ON, bcd_out SHALL present the display value of digit idx, so the decoder settles before the anode turns on.
REQ-023 The display value SHALL be the shadow nibble of the digit, except that it SHALL be 4'hF (blank) when blank_lz=1, idx>0, and shadow digits idx..NUM_DIGITS-1 are all zero.
REQ-024 Digit 0 SHALL never be suppressed.
REQ-025 Non-BCD nibbles (A-F) SHALL be passed through unchanged; blanking them is the decoder's job.
REQ-026 load=1 SHALL capture digits into a pending register and set upd_pending=1 on the next edge.
REQ-027 A further load before the transfer SHALL overwrite the pending value.
REQ-028 The pending value SHALL be copied into the shadow register on the same edge the wrap to idx=0 occurs, and upd_pending SHALL clear there.
REQ-029 If load=1 on that same edge, the new digits SHALL go to pending and upd_pending SHALL remain 1.
REQ-030 While in IDLE, a pending value SHALL be copied to the shadow register on the edge after load.
REQ-031 en=0 in any state SHALL force IDLE on the next edge: an all ones, idx=0, counter=0, bcd_out=4'hF, frame_done=0, with pending and shadow contents kept.
REQ-032 blank_lz SHALL be sampled every cycle and take effect on bcd_out on the next edge.

Reset
REQ-033 On a clk edge with rst_n=0, the block SHALL set state=IDLE, idx=0, counter=0, an all ones, bcd_out=4'hF, frame_done=0, upd_pending=0, and pending and shadow to all zero.
REQ-034 Reset SHALL take priority over en and load, and a reset mid-scan SHALL discard any pending update.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYC=1)
REQ-035 The bench SHALL cover: reset, then en=1 with shadow 0 -> an sequence 1111 (1 cycle), 1110 (4 cycles), 1111, 1101, ... through 0111; frame_done pulses every 20 cycles.
REQ-036 The bench SHALL cover: load digits=16'h1234 while in IDLE, then en=1 -> bcd_out 4,3,2,1 aligned with an[0..3] low.
REQ-037 The bench SHALL cover: load 16'h0056 mid-frame -> upd_pending=1, old value kept until the wrap, new value from digit 0 of the next frame, upd_pending=0 on the frame_done cycle.
REQ-038 The bench SHALL cover: blank_lz=1 with shadow 16'h0000 -> bcd_out F,F,F on digits 3..1, 0 on digit 0; with shadow 16'h0102 -> digit 3 = F, digit 2 = 1, digit 1 = 0, digit 0 = 2.
REQ-039 The bench SHALL cover: en dropped during ON of digit 2 -> next cycle an=1111, bcd_out=F, idx=0; re-enable restarts at GUARD of digit 0.
REQ-040 The bench SHALL cover: rst_n=0 for one cycle with upd_pending=1 mid-scan -> all outputs at reset values and upd_pending=0 on the next edge.
